// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer path.
//   ser_state_t : serializer FSM states (IDLE, SHIFT, GAP)
//   SER_WIDTH   : default word width
//   CNT_W(w)    : width of a counter that spans 0..w-1
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH = 4;

  // Clamped to 1 so a counter never collapses to zero width.
  function automatic int CNT_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser_skid_buf.sv
// One-entry valid/ready holding register.
//   clk, reset     : clock, asynchronous active-low reset
//   in_data/valid  : upstream word and its valid
//   in_ready       : entry is empty (word accepted when in_valid && in_ready)
//   take           : consumer pulls the held word this edge (only while full)
//   hold_data/full : held word and occupancy flag
//
// Handshake: a transfer happens on every rising edge where valid and ready
// are both high; valid may not depend on ready, and data is only sampled on
// that edge. Accept needs the entry empty while take needs it full, so the
// two never coincide.
module ser_skid_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  assign in_ready = !hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (in_valid && !hold_full) begin
      hold_data <= in_data;
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out word serializer feeding a SIPO register.
//   clk, reset  : clock, asynchronous active-low reset
//   in_data     : parallel word; in_valid/in_ready handshake
//   pause       : freezes shifting and gap counting (not the input side)
//   data, shift : serial bit and its sample strobe for the downstream SIPO
//   frame_done  : high with the strobe of the last bit of each word
//   busy        : FSM active or a word is held
//   state_dbg   : current FSM state, for observation
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pause,
  output logic             data,
  output logic             shift,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int             CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  BIT_ONE  = CW'(1);
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]     GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    bitcnt;
  logic [3:0]       gapcnt;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             take;
  logic             last_bit;
  logic             word_end;
  logic             gap_end;

  ser_skid_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (take),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  assign last_bit = (bitcnt == BIT_LAST);
  assign word_end = (state == SHIFT) && !pause && last_bit;
  assign gap_end  = (state == GAP) && !pause && (gapcnt == GAP_LAST);

  // Held word moves into shreg from IDLE, at the end of a word when there
  // is no gap (keeps the strobe continuous), or at the end of the gap.
  assign take = hold_full && ((state == IDLE) || (word_end && !HAS_GAP) || gap_end);

  // Output end of the register is bit WIDTH-1 for MSB-first, bit 0 otherwise.
  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST != 0) shreg_next = {shreg[WIDTH-2:0], 1'b0};
    else                shreg_next = {1'b0, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg  <= hold_data;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          if (!pause) begin
            shreg  <= shreg_next;
            bitcnt <= bitcnt + BIT_ONE;
            if (last_bit) begin
              bitcnt <= '0;
              if (HAS_GAP) begin
                gapcnt <= 4'd0;
                state  <= GAP;
              end else if (hold_full) begin
                shreg <= hold_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        GAP: begin
          if (!pause) begin
            gapcnt <= gapcnt + 4'd1;
            if (gapcnt == GAP_LAST) begin
              if (hold_full) begin
                shreg  <= hold_data;
                bitcnt <= '0;
                state  <= SHIFT;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign data       = (state == SHIFT) &&
                      ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
  assign shift      = (state == SHIFT) && !pause;
  assign frame_done = shift && last_bit;
  assign busy       = (state != IDLE) || hold_full;
  assign state_dbg  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer.
//   dut_a : WIDTH=4, MSB_FIRST=1, GAP_CYCLES=1 (with a 4-bit SIPO model)
//   dut_b : WIDTH=4, MSB_FIRST=0, GAP_CYCLES=0
// Inputs are driven 1 time unit after the rising edge, outputs checked 1
// unit later, so nothing is sampled on the active edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] a_in_data, b_in_data;
  logic       a_in_valid, b_in_valid;
  logic       a_pause, b_pause;
  logic       a_in_ready, b_in_ready;
  logic       a_data, b_data;
  logic       a_shift, b_shift;
  logic       a_frame_done, b_frame_done;
  logic       a_busy, b_busy;
  logic [1:0] a_state, b_state;
  logic [3:0] a_q;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .pause(a_pause), .data(a_data), .shift(a_shift),
    .frame_done(a_frame_done), .busy(a_busy), .state_dbg(a_state)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .pause(b_pause), .data(b_data), .shift(b_shift),
    .frame_done(b_frame_done), .busy(b_busy), .state_dbg(b_state)
  );

  // Downstream 4-bit SIPO as seen by dut_a.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       a_q <= 4'd0;
    else if (a_shift) a_q <= {a_q[2:0], a_data};
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic sh, input logic d, input logic fd);
    check({tag, "/a_shift"}, 32'(a_shift), 32'(sh));
    check({tag, "/a_data"}, 32'(a_data), 32'(d));
    check({tag, "/a_frame_done"}, 32'(a_frame_done), 32'(fd));
  endtask

  task automatic chk_b(input string tag, input logic sh, input logic d, input logic fd);
    check({tag, "/b_shift"}, 32'(b_shift), 32'(sh));
    check({tag, "/b_data"}, 32'(b_data), 32'(d));
    check({tag, "/b_frame_done"}, 32'(b_frame_done), 32'(fd));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = 4'd0; a_in_valid = 1'b0; a_pause = 1'b0;
    b_in_data = 4'd0; b_in_valid = 1'b0; b_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst/a_in_ready", 32'(a_in_ready), 32'd1);
    chk_a("rst", 1'b0, 1'b0, 1'b0);
    check("rst/a_busy", 32'(a_busy), 32'd0);
    check("rst/a_state", 32'(a_state), 32'd0);
    check("rst/b_in_ready", 32'(b_in_ready), 32'd1);
    check("rst/b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;

    // Idle stability: 20 cycles with in_valid low
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk_a("idle", 1'b0, 1'b0, 1'b0);
      check("idle/a_busy", 32'(a_busy), 32'd0);
      check("idle/b_shift", 32'(b_shift), 32'd0);
      check("idle/b_busy", 32'(b_busy), 32'd0);
    end

    // Single word 1011, MSB first
    a_in_data = 4'b1011; a_in_valid = 1'b1; #1;
    check("t1/ready_pre", 32'(a_in_ready), 32'd1);
    cyc(); a_in_valid = 1'b0; #1;
    check("t1/ready_held", 32'(a_in_ready), 32'd0);
    check("t1/busy_held", 32'(a_busy), 32'd1);
    check("t1/shift_held", 32'(a_shift), 32'd0);
    cyc(); #1; chk_a("t1_b0", 1'b1, 1'b1, 1'b0);
    check("t1/ready_back", 32'(a_in_ready), 32'd1);
    cyc(); #1; chk_a("t1_b1", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_a("t1_b2", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t1_b3", 1'b1, 1'b1, 1'b1);
    cyc(); #1; chk_a("t1_gap", 1'b0, 1'b0, 1'b0);
    check("t1/gap_busy", 32'(a_busy), 32'd1);
    check("t1/gap_state", 32'(a_state), 32'd2);
    check("t1/sipo_q", 32'(a_q), 32'hB);
    cyc(); #1;
    check("t1/end_busy", 32'(a_busy), 32'd0);
    check("t1/end_state", 32'(a_state), 32'd0);

    // Back-to-back A then 5 with one gap cycle
    a_in_data = 4'hA; a_in_valid = 1'b1; #1;
    cyc(); a_in_data = 4'h5; #1;
    check("t2/ready_drop", 32'(a_in_ready), 32'd0);
    cyc(); #1; chk_a("t2_a0", 1'b1, 1'b1, 1'b0);
    check("t2/ready_c1", 32'(a_in_ready), 32'd1);
    cyc(); a_in_valid = 1'b0; #1; chk_a("t2_a1", 1'b1, 1'b0, 1'b0);
    check("t2/second_held", 32'(a_in_ready), 32'd0);
    cyc(); #1; chk_a("t2_a2", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t2_a3", 1'b1, 1'b0, 1'b1);
    cyc(); #1; chk_a("t2_gap", 1'b0, 1'b0, 1'b0);
    check("t2/gap_state", 32'(a_state), 32'd2);
    check("t2/sipo_qA", 32'(a_q), 32'hA);
    cyc(); #1; chk_a("t2_50", 1'b1, 1'b0, 1'b0);
    check("t2/ready_re", 32'(a_in_ready), 32'd1);
    cyc(); #1; chk_a("t2_51", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t2_52", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_a("t2_53", 1'b1, 1'b1, 1'b1);
    cyc(); #1; chk_a("t2_gap2", 1'b0, 1'b0, 1'b0);
    check("t2/sipo_q5", 32'(a_q), 32'h5);
    cyc(); #1;
    check("t2/end_busy", 32'(a_busy), 32'd0);

    // No gap, LSB first: 1 then 8 continuously
    b_in_data = 4'h1; b_in_valid = 1'b1; #1;
    cyc(); b_in_data = 4'h8; #1;
    check("t3/ready_drop", 32'(b_in_ready), 32'd0);
    cyc(); #1; chk_b("t3_c1", 1'b1, 1'b1, 1'b0);
    check("t3/ready_c1", 32'(b_in_ready), 32'd1);
    cyc(); b_in_valid = 1'b0; #1; chk_b("t3_c2", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_b("t3_c3", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_b("t3_c4", 1'b1, 1'b0, 1'b1);
    cyc(); #1; chk_b("t3_c5", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_b("t3_c6", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_b("t3_c7", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_b("t3_c8", 1'b1, 1'b1, 1'b1);
    cyc(); #1; chk_b("t3_c9", 1'b0, 1'b0, 1'b0);
    check("t3/end_busy", 32'(b_busy), 32'd0);

    // Pause for 3 cycles while the 2nd bit of C is presented
    a_in_data = 4'hC; a_in_valid = 1'b1; #1;
    cyc(); a_in_valid = 1'b0; #1;
    cyc(); #1; chk_a("t4_c1", 1'b1, 1'b1, 1'b0);
    cyc(); a_pause = 1'b1; #1; chk_a("t4_p1", 1'b0, 1'b1, 1'b0);
    check("t4/p1_busy", 32'(a_busy), 32'd1);
    cyc(); #1; chk_a("t4_p2", 1'b0, 1'b1, 1'b0);
    cyc(); #1; chk_a("t4_p3", 1'b0, 1'b1, 1'b0);
    cyc(); a_pause = 1'b0; #1; chk_a("t4_c5", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t4_c6", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_a("t4_c7", 1'b1, 1'b0, 1'b1);
    cyc(); #1; chk_a("t4_gap", 1'b0, 1'b0, 1'b0);
    check("t4/sipo_q", 32'(a_q), 32'hC);
    cyc(); #1;
    check("t4/end_busy", 32'(a_busy), 32'd0);

    // Reset mid-word of 9 with F held, then send 6
    a_in_data = 4'h9; a_in_valid = 1'b1; #1;
    cyc(); a_in_data = 4'hF; #1;
    cyc(); #1; chk_a("t5_c1", 1'b1, 1'b1, 1'b0);
    check("t5/ready_c1", 32'(a_in_ready), 32'd1);
    cyc(); a_in_valid = 1'b0; #1; chk_a("t5_c2", 1'b1, 1'b0, 1'b0);
    check("t5/held", 32'(a_in_ready), 32'd0);
    cyc(); #2;
    rst_n = 1'b0; #1;
    chk_a("t5_rst", 1'b0, 1'b0, 1'b0);
    check("t5/rst_busy", 32'(a_busy), 32'd0);
    check("t5/rst_ready", 32'(a_in_ready), 32'd1);
    check("t5/rst_state", 32'(a_state), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    a_in_data = 4'h6; a_in_valid = 1'b1; #1;
    cyc(); a_in_valid = 1'b0; #1;
    cyc(); #1; chk_a("t5_60", 1'b1, 1'b0, 1'b0);
    cyc(); #1; chk_a("t5_61", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t5_62", 1'b1, 1'b1, 1'b0);
    cyc(); #1; chk_a("t5_63", 1'b1, 1'b0, 1'b1);
    cyc(); #1; chk_a("t5_gap", 1'b0, 1'b0, 1'b0);
    check("t5/sipo_q", 32'(a_q), 32'h6);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk_a("t5_after", 1'b0, 1'b0, 1'b0);
      check("t5/after_busy", 32'(a_busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out word serializer sitting directly upstream of the 4-bit SIPO register. It accepts WIDTH-bit words over a valid/ready handshake, buffers one word while another is shifting, and drives a serial `data` bit plus a `shift` strobe that connect straight to the SIPO's `data`/`shift` inputs. A `pause` input stalls shifting mid-word, and a configurable inter-word gap gives the downstream stage time to sample its parallel output.

## Interface
- `WIDTH`, 4: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `GAP_CYCLES`, 1: idle cycles inserted after each word (0 to 15).

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; asserting it low clears all state immediately.
- `in_data` in WIDTH: parallel word to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: holding register is empty; a word is accepted on any edge where `in_valid && in_ready`.
- `pause` in 1: when 1, freezes shifting and gap counting. Has no effect on the input handshake.
- `data` out 1: current serial bit; connects to the SIPO `data` input.
- `shift` out 1: strobe; downstream samples `data` on every edge where `shift` is 1.
- `frame_done` out 1: 1 during the cycle carrying the last bit of a word, coincident with its `shift`.
- `busy` out 1: FSM is not IDLE, or the holding register is full.

## Operation
- Storage:
  - `hold` (WIDTH) and `hold_full`, the one-word skid buffer.
  - `shreg` (WIDTH), the shift register.
  - `bitcnt`, counts 0 to WIDTH-1.
  - `gapcnt`, 4 bits.
- Input handshake:
  - `in_ready = !hold_full`.
  - On an accept edge, `hold <= in_data` and `hold_full <= 1`.
  - An accept and a hold→shreg transfer can never occur on the same edge.
- FSM states: IDLE, SHIFT, GAP.
  - **IDLE:** if `hold_full`, then `shreg <= hold`, `hold_full <= 0`, `bitcnt <= 0`, go to SHIFT. This transfer is independent of `pause`.
  - **SHIFT:** on each edge with `pause == 0`:
    - `shreg` shifts toward the output end.
    - `bitcnt` increments.
    - When `bitcnt == WIDTH-1`, the word ends: go to GAP with `gapcnt <= 0` if `GAP_CYCLES > 0`. Otherwise load the next word if `hold_full`, or return to IDLE.
  - **GAP:** on each edge with `pause == 0`, `gapcnt` increments. At `gapcnt == GAP_CYCLES-1`, load the next word if `hold_full`, or return to IDLE.
- Output logic (combinational from registers and `pause`):
  - `data` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
  - `data` = 0 outside SHIFT.
  - `shift = (state == SHIFT) && !pause`.
  - `frame_done = shift && (bitcnt == WIDTH-1)`.
- Reset values: all outputs are 0 except `in_ready`, which is 1. State is IDLE, `hold_full = 0`, and all counters are 0.
- Reset mid-word: the partial word and any held word are discarded, and no `frame_done` is issued. After release, the next accepted word is sent in full.

## Timing
- Latency: for a word accepted at edge E0 with the FSM idle, the word enters `shreg` at E1. The first `shift` is high in the cycle after E1, and the downstream SIPO captures bit 0 of the stream at E2.
- Word duration: WIDTH strobe cycles plus GAP_CYCLES idle cycles, assuming no pause.
- Each `pause` cycle in SHIFT or GAP extends the word by exactly one cycle. `data` holds steady during a pause.
- Throughput with back-to-back input: one word per WIDTH+GAP_CYCLES cycles. With GAP_CYCLES=0, `shift` stays high continuously with no bubble.
- `in_ready` deasserts the cycle after an accept. It reasserts the cycle after the held word transfers into `shreg`.

## Structure
- Shared package `serdes_pkg`:
  - State enum `ser_state_t` {IDLE, SHIFT, GAP}.
  - Default-width constant `SER_WIDTH = 4`.
  - Helper `CNT_W(w) = $clog2(w)`.
- Sub-module `ser_skid_buf`: a one-entry valid/ready holding register, reusable ahead of the SIPO path. The FSM, shift register and counters live in the top module.

## Test plan
- Single word: WIDTH=4, MSB_FIRST=1, send 4'b1011 → `shift` high for 4 cycles with `data` = 1,0,1,1. `frame_done` is high on the 4th cycle only. The downstream SIPO holds q=1011 afterwards.
- Back-to-back: send 4'hA then 4'h5 with GAP_CYCLES=1 → `in_ready` drops after the first accept. The second word is accepted while the first shifts. Bit streams are 1010, then 1 idle cycle, then 0101.
- GAP_CYCLES=0, MSB_FIRST=0, send 4'h1, 4'h8 continuously → 8 consecutive `shift` cycles carrying 1000 0001. `frame_done` is high on cycles 4 and 8.
- Pause: send 4'hC and hold `pause` high for 3 cycles after the 2nd bit → `shift` is low for 3 cycles and `data` holds 1. The total word spans 7 strobe-window cycles and bits are 1,1,0,0.
- Reset mid-word: drive `reset` low after the 2nd bit of 4'h9 with a word held → all outputs are 0 immediately and `in_ready` is 1. After release, sending 4'h6 yields exactly 0,1,1,0.
- Idle stability: leave `in_valid` low for 20 cycles after reset → `shift`, `busy` and `frame_done` stay 0.
